// File: rtl/load_store_queue.sv
// In-order load/store queue: FIFO of memory ops, one outstanding request, CDB broadcast of load data.
// Optional WAIT watchdog with timeout_err port when LSQ_TIMEOUT_EN is defined.
module load_store_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [42:0] issue_instr,
  output logic        issue_ready,
  output logic        key_mem,
  output logic [42:0] mem_instr,
  input  logic        mem_done,
  input  logic [22:0] mem_solution,
  output logic        cdb_valid,
  output logic [2:0]  cdb_tag,
  output logic [3:0]  cdb_reg,
  output logic [15:0] cdb_data,
  input  logic        cdb_grant,
`ifdef LSQ_TIMEOUT_EN
  output logic        timeout_err,
`endif
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    BCAST
  } state_t;

  logic [42:0]   fifo_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [2:0]    tag_q, tag_d;
  logic [3:0]    reg_q, reg_d;
  logic [15:0]   data_q, data_d;

  logic [42:0] head_ent;
  logic        push;
  logic        pop;
  logic        match;
  logic        tmo;

  assign head_ent    = fifo_q[head_q];
  assign issue_ready = (count_q != CW'(DEPTH));
  assign push        = issue_valid && issue_ready && issue_instr[39];
  assign match       = mem_done && (mem_solution[18:16] == head_ent[42:40]);

`ifdef LSQ_TIMEOUT_EN
  logic [3:0] wdog_q, wdog_d;

  // Fires on the 15th consecutive WAIT cycle without a matching response
  assign tmo         = (state_q == WAIT) && !match && (wdog_q == 4'd14);
  assign timeout_err = tmo;
  assign wdog_d      = (state_q == WAIT) ? wdog_q + 4'd1 : 4'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wdog_q <= 4'd0;
    else       wdog_q <= wdog_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tag_d   = tag_q;
    reg_d   = reg_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = SEND;
      end
      SEND: begin
        if (head_ent[38]) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (match) begin
          pop     = 1'b1;
          tag_d   = head_ent[42:40];
          reg_d   = mem_solution[22:19];
          data_d  = mem_solution[15:0];
          state_d = BCAST;
        end else if (tmo) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      BCAST: begin
        if (cdb_grant) state_d = IDLE;
      end
    endcase
  end

  assign head_d  = pop  ? head_q + AW'(1) : head_q;
  assign tail_d  = push ? tail_q + AW'(1) : tail_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      tag_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      tag_q   <= tag_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

  // Entry storage needs no reset: only slots covered by count_q are ever read
  always_ff @(posedge clock) begin
    if (push) fifo_q[tail_q] <= issue_instr;
  end

  assign key_mem   = (state_q == SEND);
  assign mem_instr = key_mem ? head_ent : '0;
  assign cdb_valid = (state_q == BCAST);
  assign cdb_tag   = tag_q;
  assign cdb_reg   = reg_q;
  assign cdb_data  = data_q;
  assign busy      = (count_q != '0) || (state_q != IDLE);

endmodule
